// File: rtl/uart_alu_sequencer.sv
// Purpose : collects MSB-first operand A and B bytes and an opcode byte from the UART rx stream,
//           runs the combinational ALU for one cycle, then streams the result back out byte by byte.
// Latency : 2 cycles from the opcode strobe to the first o_tx_start.
// Backpressure: each tx byte waits for i_tx_done; rx strobes arriving while busy are dropped.
// Build option: UART_ALU_SEQ_CHECKSUM_EN appends an XOR checksum byte after the result bytes.
module uart_alu_sequencer #(
  parameter int NB_BYTE        = 8,
  parameter int NB_DATA        = 16,
  parameter int NB_OPCODE      = 6,
  parameter int N_BYTES        = NB_DATA / NB_BYTE,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_BYTE-1:0]   i_rx_data,
  input  logic                 i_rx_data_valid,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_tx_done,
  output logic [NB_DATA-1:0]   o_first_operator,
  output logic [NB_DATA-1:0]   o_second_operator,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic                 o_tx_start,
  output logic [NB_BYTE-1:0]   o_tx_data,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [2:0]           o_dbg_state
);

  // Room for N_BYTES result bytes plus an optional checksum byte.
  localparam int NB_CNT = $clog2(N_BYTES + 2);
  localparam logic [NB_CNT-1:0]     CNT_LAST = NB_CNT'(N_BYTES - 1);
  localparam logic [NB_TIMEOUT-1:0] TO_LAST  = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] RX_A      = 3'd0;
  localparam logic [2:0] RX_B      = 3'd1;
  localparam logic [2:0] RX_OP     = 3'd2;
  localparam logic [2:0] EXEC      = 3'd3;
  localparam logic [2:0] SEND      = 3'd4;
  localparam logic [2:0] WAIT_DONE = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  logic [NB_TIMEOUT-1:0] to_q, to_d;
  logic [NB_DATA-1:0]   a_q, a_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_OPCODE-1:0] op_q, op_d;
  logic [NB_DATA-1:0]   res_q, res_d;
  logic                 tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
  logic                 timeout_q, timeout_d;
`ifdef UART_ALU_SEQ_CHECKSUM_EN
  logic [NB_BYTE-1:0]   csum_q, csum_d;
`endif

  logic                 to_active;
  logic                 expire;
  logic                 cnt_is_last;
  logic [NB_DATA-1:0]   res_shift;
  logic [NB_DATA-1:0]   rx_ext;

  // The inter-byte timer only runs while a frame is partially assembled.
  assign to_active   = ((state_q == RX_A) && (cnt_q != '0)) || (state_q == RX_B) || (state_q == RX_OP);
  // A strobe in the expiry cycle takes priority, so expiry requires an idle cycle.
  assign expire      = to_active && !i_rx_data_valid && (to_q == TO_LAST);
  assign cnt_is_last = (cnt_q == CNT_LAST);
  assign res_shift   = res_q << NB_BYTE;
  assign rx_ext      = NB_DATA'(i_rx_data);

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RX_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_A: begin
        if (expire)                              state_d = RX_A;
        else if (i_rx_data_valid && cnt_is_last) state_d = RX_B;
      end
      RX_B: begin
        if (expire)                              state_d = RX_A;
        else if (i_rx_data_valid && cnt_is_last) state_d = RX_OP;
      end
      RX_OP: begin
        if (expire)               state_d = RX_A;
        else if (i_rx_data_valid) state_d = EXEC;
      end
      EXEC: state_d = SEND;
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done) begin
`ifdef UART_ALU_SEQ_CHECKSUM_EN
          // Last result byte is followed by the checksum byte.
          if (cnt_q == NB_CNT'(N_BYTES)) state_d = RX_A;
          else                           state_d = SEND;
`else
          if (cnt_is_last) state_d = RX_A;
          else             state_d = SEND;
`endif
        end
      end
      default: state_d = RX_A;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d      = cnt_q;
    to_d       = '0;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    tx_data_d  = tx_data_q;
    tx_start_d = (state_d == SEND);
    timeout_d  = expire;
`ifdef UART_ALU_SEQ_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (to_active && !i_rx_data_valid && !expire) begin
      to_d = to_q + 1'b1;
    end

    case (state_q)
      RX_A: begin
        if (i_rx_data_valid) begin
          a_d   = (a_q << NB_BYTE) | rx_ext;
          cnt_d = cnt_is_last ? '0 : cnt_q + 1'b1;
        end else if (expire) begin
          cnt_d = '0;
        end
      end
      RX_B: begin
        if (i_rx_data_valid) begin
          b_d   = (b_q << NB_BYTE) | rx_ext;
          cnt_d = cnt_is_last ? '0 : cnt_q + 1'b1;
        end else if (expire) begin
          cnt_d = '0;
        end
      end
      RX_OP: begin
        if (i_rx_data_valid) begin
          op_d = i_rx_data[NB_OPCODE-1:0];
        end else if (expire) begin
          cnt_d = '0;
        end
      end
      EXEC: begin
        res_d     = i_alu_result;
        cnt_d     = '0;
        tx_data_d = i_alu_result[NB_DATA-1 -: NB_BYTE];
`ifdef UART_ALU_SEQ_CHECKSUM_EN
        csum_d    = i_alu_result[NB_DATA-1 -: NB_BYTE];
`endif
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          res_d = res_shift;
          cnt_d = cnt_q + 1'b1;
          if (state_d == RX_A) begin
            cnt_d = '0;
          end else begin
`ifdef UART_ALU_SEQ_CHECKSUM_EN
            if (cnt_is_last) begin
              tx_data_d = csum_q;
            end else begin
              tx_data_d = res_shift[NB_DATA-1 -: NB_BYTE];
              csum_d    = csum_q ^ res_shift[NB_DATA-1 -: NB_BYTE];
            end
`else
            tx_data_d = res_shift[NB_DATA-1 -: NB_BYTE];
`endif
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q      <= '0;
      to_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
`ifdef UART_ALU_SEQ_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
`ifdef UART_ALU_SEQ_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Output decode.
  always_comb begin
    o_first_operator  = a_q;
    o_second_operator = b_q;
    o_opcode          = op_q;
    o_tx_start        = tx_start_q;
    o_tx_data         = tx_data_q;
    o_timeout         = timeout_q;
    o_busy            = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_DONE);
    o_dbg_state       = state_q;
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer: framing, tx handshake, timeout, dropped strobes, reset.
// The ALU is modelled as A+B; expected bytes are hand-computed constants.
// Checksum expectations follow UART_ALU_SEQ_CHECKSUM_EN.
module tb_uart_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_vld = 1'b0;
  logic [15:0] alu_result;
  logic        tx_done = 1'b0;
  logic [15:0] first_op, second_op;
  logic [5:0]  opcode;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy, timeout;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int tout_cnt = 0;
  int dbl = 0;
  logic prev_start = 1'b0;
  int tx_before;

  uart_alu_sequencer #(
    .NB_BYTE(8), .NB_DATA(16), .NB_OPCODE(6), .N_BYTES(2), .TIMEOUT_CYCLES(50), .NB_TIMEOUT(6)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_data_valid(rx_vld),
    .i_alu_result(alu_result), .i_tx_done(tx_done),
    .o_first_operator(first_op), .o_second_operator(second_op), .o_opcode(opcode),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy), .o_timeout(timeout),
    .o_dbg_state(dbg_state)
  );

  assign alu_result = first_op + second_op;

  always #5 clk = ~clk;

  // Observe tx starts and timeout pulses mid-cycle.
  always @(negedge clk) begin
    if (tx_start === 1'b1) tx_cnt++;
    if (tx_start === 1'b1 && prev_start === 1'b1) dbl++;
    prev_start = tx_start;
    if (timeout === 1'b1) tout_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a1, input logic [7:0] a0,
                            input logic [7:0] b1, input logic [7:0] b0, input logic [7:0] op);
    send_byte(a1); send_byte(a0); send_byte(b1); send_byte(b0); send_byte(op);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  // Wait (bounded) for the next tx start, check its byte, optionally acknowledge it.
  task automatic expect_tx(input logic [7:0] exp, input string tag, input bit do_done);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, {31'd0, tx_start}, 32'd1);
    check({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
    if (do_done) pulse_done();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_first_op", {16'd0, first_op}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("idle_no_timeout", tout_cnt, 0);

    // Frame 1: 0x1234 + 0x0011 = 0x1245
    send_frame(8'h12, 8'h34, 8'h00, 8'h11, 8'h20);
    @(negedge clk);
    check("f1_exec_state", {29'd0, dbg_state}, 32'd3);
    check("f1_exec_no_start", {31'd0, tx_start}, 32'd0);
    check("f1_exec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("f1_latency_start", {31'd0, tx_start}, 32'd1);
    check("f1_byte0", {24'd0, tx_data}, 32'h12);
    check("f1_send_state", {29'd0, dbg_state}, 32'd4);
    check("f1_first_op", {16'd0, first_op}, 32'h1234);
    check("f1_second_op", {16'd0, second_op}, 32'h0011);
    check("f1_opcode", {26'd0, opcode}, 32'h20);
    @(negedge clk);
    check("f1_wait_state", {29'd0, dbg_state}, 32'd5);
    check("f1_start_one_cycle", {31'd0, tx_start}, 32'd0);
    check("f1_tx_data_hold", {24'd0, tx_data}, 32'h12);
    pulse_done();
    expect_tx(8'h45, "f1_byte1", 1'b1);
`ifdef UART_ALU_SEQ_CHECKSUM_EN
    expect_tx(8'h57, "f1_csum", 1'b1);
`endif
    @(negedge clk);
    check("f1_back_rx_a", {29'd0, dbg_state}, 32'd0);
    check("f1_not_busy", {31'd0, busy}, 32'd0);

    // Timeout after one byte of A
    send_byte(8'hAA);
    repeat (50) @(negedge clk);
    check("to_before_expiry", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    check("to_pulse", {31'd0, timeout}, 32'd1);
    check("to_state", {29'd0, dbg_state}, 32'd0);
    check("to_operand_kept", {16'd0, first_op}, 32'h34AA);
    @(negedge clk);
    check("to_pulse_single", {31'd0, timeout}, 32'd0);
    check("to_count", tout_cnt, 1);

    // Frame 2 after resync: 0x0002 + 0x0003 = 0x0005
    send_frame(8'h00, 8'h02, 8'h00, 8'h03, 8'h20);
    expect_tx(8'h00, "f2_byte0", 1'b1);
    expect_tx(8'h05, "f2_byte1", 1'b1);
`ifdef UART_ALU_SEQ_CHECKSUM_EN
    expect_tx(8'h05, "f2_csum", 1'b1);
`endif
    check("f2_first_op", {16'd0, first_op}, 32'h0002);

    // Frame 3: opcode upper bits dropped, rx strobes in WAIT_DONE ignored
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hC5);
    expect_tx(8'h04, "f3_byte0", 1'b0);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    @(negedge clk);
    check("f3_still_wait", {29'd0, dbg_state}, 32'd5);
    check("f3_first_op", {16'd0, first_op}, 32'h0102);
    check("f3_second_op", {16'd0, second_op}, 32'h0304);
    check("f3_opcode", {26'd0, opcode}, 32'h05);
    pulse_done();
    expect_tx(8'h06, "f3_byte1", 1'b1);
`ifdef UART_ALU_SEQ_CHECKSUM_EN
    expect_tx(8'h02, "f3_csum", 1'b1);
`endif
    @(negedge clk);
    check("f3_back_rx_a", {29'd0, dbg_state}, 32'd0);

    // Strobe in the expiry cycle wins
    send_byte(8'hAA);
    repeat (48) @(posedge clk);
    send_byte(8'hBB);
    @(negedge clk);
    check("co_state_rx_b", {29'd0, dbg_state}, 32'd1);
    check("co_no_timeout", tout_cnt, 1);
    send_byte(8'h00); send_byte(8'h07); send_byte(8'h20);
    expect_tx(8'hAA, "co_byte0", 1'b1);
    expect_tx(8'hC2, "co_byte1", 1'b1);
`ifdef UART_ALU_SEQ_CHECKSUM_EN
    expect_tx(8'h68, "co_csum", 1'b1);
`endif
    check("co_first_op", {16'd0, first_op}, 32'hAABB);
    check("co_second_op", {16'd0, second_op}, 32'h0007);

    // Reset during WAIT_DONE
    send_frame(8'h01, 8'h00, 8'h02, 8'h00, 8'h20);
    expect_tx(8'h03, "rs_byte0", 1'b0);
    @(posedge clk); #1;
    check("rs_pre_wait", {29'd0, dbg_state}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("rs_async_state", {29'd0, dbg_state}, 32'd0);
    check("rs_async_tx_data", {24'd0, tx_data}, 32'd0);
    check("rs_async_first_op", {16'd0, first_op}, 32'd0);
    check("rs_async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_before = tx_cnt;
    pulse_done();
    repeat (20) @(negedge clk);
    check("rs_no_more_tx", tx_cnt, tx_before);
    check("rs_idle_state", {29'd0, dbg_state}, 32'd0);

    // Whole-run properties
    check("no_back_to_back_start", dbl, 0);
`ifdef UART_ALU_SEQ_CHECKSUM_EN
    check("total_tx_bytes", tx_cnt, 13);
`else
    check("total_tx_bytes", tx_cnt, 9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
